// File: rtl/wos_pkg.sv
// Shared types and helpers for the WOS filter sequencer: FSM state encoding,
// pixel width, kernel-size validation and column-slot bit indexing.
package wos_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Kernel side must be odd, non-zero, within the column bus and fit the image.
  function automatic logic n_ok(input logic [7:0] n, input logic [7:0] h,
                                input logic [7:0] w, input int max_n);
    return (n != 8'd0) && n[0] && (int'(n) <= max_n) && (n <= h) && (n <= w);
  endfunction

  function automatic int slot_lsb(input int k);
    return k * PIX_W;
  endfunction

endpackage

// File: rtl/wos_filter_ctrl_if.sv
// Memory and kernel bus of the WOS filter sequencer. Strobes are single-cycle
// qualifiers with no back-pressure: a consumer must accept every strobed beat.
interface wos_filter_ctrl_if
  import wos_pkg::*;
#(
  parameter int MAX_N  = 5,
  parameter int ADDR_W = 16
);
  logic                    o_rd_en;
  logic [ADDR_W-1:0]       o_rd_addr;
  logic [PIX_W-1:0]        i_rd_data;
  logic                    o_col_valid;
  logic [MAX_N*PIX_W-1:0]  o_col_data;
  logic                    o_newline;
  logic [PIX_W-1:0]        i_kernel_out;
  logic                    o_wr_en;
  logic [ADDR_W-1:0]       o_wr_addr;
  logic [PIX_W-1:0]        o_wr_data;

  modport master (
    output o_rd_en, o_rd_addr, o_col_valid, o_col_data, o_newline,
    output o_wr_en, o_wr_addr, o_wr_data,
    input  i_rd_data, i_kernel_out
  );

  modport slave (
    input  o_rd_en, o_rd_addr, o_col_valid, o_col_data, o_newline,
    input  o_wr_en, o_wr_addr, o_wr_data,
    output i_rd_data, i_kernel_out
  );
endinterface

// File: rtl/wos_valid_delay.sv
// Fixed-depth shift register with async active-low clear. The MSB of each word
// is treated as its valid flag; any_valid reports whether any stage holds one.
module wos_valid_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_valid
);
  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stages[i][WIDTH-1];
  end
endmodule

// File: rtl/wos_filter_ctrl.sv
// WOS filter sequencer: streams image columns from memory into the rank-order
// kernel and writes each valid-window result back to the output region.
module wos_filter_ctrl
  import wos_pkg::*;
#(
  parameter int MAX_N      = 5,
  parameter int ADDR_W     = 16,
  parameter int IN_BASE    = 0,
  parameter int OUT_BASE   = 512,
  parameter int KERNEL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_h,
  input  logic [7:0] i_w,
  input  logic [7:0] i_n,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output state_t     state_dbg,
  wos_filter_ctrl_if.master bus
);
  state_t            state;
  logic [7:0]        h_q, w_q, n_q;
  logic [7:0]        r, c, k;
  logic [ADDR_W-1:0] col_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy, done, err;

  // Read-return stage: metadata of the read issued last cycle, aligned with i_rd_data.
  logic              d1_en, d1_last, d1_first, d1_wv;
  logic [7:0]        d1_k;
  logic [PIX_W-1:0]  slots [MAX_N];
  logic              col_valid, newline, col_wv;
  logic [ADDR_W-1:0] out_ptr, col_out_addr;
  logic [MAX_N*PIX_W-1:0] col_data;

  logic [ADDR_W:0]   dly_out;
  logic              dly_any;
  logic              pipe_busy;

  assign pipe_busy = d1_en | col_valid | dly_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      h_q      <= '0;
      w_q      <= '0;
      n_q      <= '0;
      r        <= '0;
      c        <= '0;
      k        <= '0;
      col_base <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            h_q   <= i_h;
            w_q   <= i_w;
            n_q   <= i_n;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!n_ok(n_q, h_q, w_q, MAX_N)) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_addr  <= ADDR_W'(IN_BASE);
            col_base <= ADDR_W'(IN_BASE);
            r        <= '0;
            c        <= '0;
            k        <= '0;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (k != n_q - 8'd1) begin
            k       <= k + 8'd1;
            rd_addr <= rd_addr + ADDR_W'(w_q);
          end else begin
            // The next column top is always one past this one, even across a row wrap.
            k        <= '0;
            col_base <= col_base + ADDR_W'(1);
            rd_addr  <= col_base + ADDR_W'(1);
            if (c != w_q - 8'd1) begin
              c <= c + 8'd1;
            end else begin
              c <= '0;
              if (r == h_q - n_q) begin
                rd_en   <= 1'b0;
                rd_addr <= '0;
                state   <= ST_DRAIN;
              end else begin
                r <= r + 8'd1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (!pipe_busy) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_en        <= 1'b0;
      d1_last      <= 1'b0;
      d1_first     <= 1'b0;
      d1_wv        <= 1'b0;
      d1_k         <= '0;
      col_valid    <= 1'b0;
      newline      <= 1'b0;
      col_wv       <= 1'b0;
      col_out_addr <= '0;
      out_ptr      <= '0;
      for (int s = 0; s < MAX_N; s++) slots[s] <= '0;
    end else begin
      d1_en     <= rd_en;
      d1_k      <= k;
      d1_last   <= (k == n_q - 8'd1);
      d1_first  <= (c == 8'd0);
      d1_wv     <= (c >= n_q - 8'd1);
      col_valid <= 1'b0;
      newline   <= 1'b0;
      if (state == ST_CHECK) begin
        out_ptr <= ADDR_W'(OUT_BASE);
        for (int s = 0; s < MAX_N; s++) slots[s] <= '0;
      end
      if (d1_en) begin
        for (int s = 0; s < MAX_N; s++)
          if (d1_k == 8'(s)) slots[s] <= bus.i_rd_data;
        // Output pixels are row-major and contiguous, so a running pointer suffices.
        if (d1_last) begin
          col_valid    <= 1'b1;
          newline      <= d1_first;
          col_wv       <= d1_wv;
          col_out_addr <= out_ptr;
          if (d1_wv) out_ptr <= out_ptr + ADDR_W'(1);
        end
      end
    end
  end

  for (genvar s = 0; s < MAX_N; s++) begin : g_col
    assign col_data[slot_lsb(s) +: PIX_W] = slots[s];
  end

  wos_valid_delay #(
    .DEPTH (KERNEL_LAT),
    .WIDTH (ADDR_W + 1)
  ) u_wr_delay (
    .clk       (clk),
    .rst_n     (rst),
    .din       ({col_valid & col_wv, col_out_addr}),
    .dout      (dly_out),
    .any_valid (dly_any)
  );

  assign bus.o_rd_en     = rd_en;
  assign bus.o_rd_addr   = rd_addr;
  assign bus.o_col_valid = col_valid;
  assign bus.o_col_data  = col_data;
  assign bus.o_newline   = newline;
  assign bus.o_wr_en     = dly_out[ADDR_W];
  assign bus.o_wr_addr   = dly_out[ADDR_W-1:0];
  assign bus.o_wr_data   = dly_out[ADDR_W] ? bus.i_kernel_out : '0;
  assign o_busy          = busy;
  assign o_done          = done;
  assign o_err           = err;
  assign state_dbg       = state;
endmodule

// File: tb/tb_wos_filter_ctrl.sv
// Directed bench for wos_filter_ctrl with a sync-RAM model, a median kernel
// model and a write scoreboard of hand-derived {addr, data} pairs.
module tb_wos_filter_ctrl;
  import wos_pkg::*;

  localparam int MAX_N    = 5;
  localparam int ADDR_W   = 16;
  localparam int OUT_BASE = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_h = '0, i_w = '0, i_n = '0;
  logic       o_busy, o_done, o_err;
  state_t     state_dbg;

  wos_filter_ctrl_if #(.MAX_N(MAX_N), .ADDR_W(ADDR_W)) bus ();

  wos_filter_ctrl #(.MAX_N(MAX_N), .ADDR_W(ADDR_W), .IN_BASE(0),
                    .OUT_BASE(OUT_BASE), .KERNEL_LAT(2)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_h(i_h), .i_w(i_w), .i_n(i_n),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .state_dbg(state_dbg),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model (sync read) ----------------
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr[9:0]];
  end

  // ---------------- median kernel model ----------------
  int         cur_n = 3;
  logic [7:0] win [MAX_N][MAX_N];
  int         wcnt = 0;
  logic [7:0] k_stage = '0;

  function automatic logic [7:0] median_win();
    int a [25];
    int cnt, t;
    cnt = 0;
    for (int j = 0; j < cur_n; j++)
      for (int i = 0; i < cur_n; i++) begin a[cnt] = int'(win[j][i]); cnt++; end
    for (int x = 0; x < cnt; x++)
      for (int y = 0; y < cnt - 1 - x; y++)
        if (a[y] > a[y+1]) begin t = a[y]; a[y] = a[y+1]; a[y+1] = t; end
    return 8'(a[cnt/2]);
  endfunction

  always @(posedge clk) begin
    logic [7:0] med;
    med = '0;
    if (bus.o_col_valid) begin
      if (bus.o_newline) wcnt = 0;
      for (int j = 0; j < cur_n - 1; j++) win[j] = win[j+1];
      for (int i = 0; i < MAX_N; i++) win[cur_n-1][i] = bus.o_col_data[i*8 +: 8];
      wcnt++;
      if (wcnt >= cur_n) med = median_win();
    end
    bus.i_kernel_out <= k_stage;
    k_stage          <= med;
  end

  // ---------------- scoreboard and counters ----------------
  logic [ADDR_W+8-1:0] exp_q [$];
  int errors = 0, checks = 0;
  int rd_cnt, wr_cnt, col_cnt, nl_cnt, done_cnt, err_cnt, busy_seen;
  int cyc = 0, last_col_cyc, min_sp, max_sp;
  logic [ADDR_W-1:0] rd_log [6];
  logic [7:0] first_wr_data;
  logic cv_d1 = 1'b0, cv_d2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; col_cnt = 0; nl_cnt = 0; done_cnt = 0;
    err_cnt = 0; busy_seen = 0; last_col_cyc = -1; min_sp = 1000; max_sp = 0;
    first_wr_data = '0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    logic [ADDR_W+8-1:0] e;
    cyc++;
    if (bus.o_rd_en) begin
      if (rd_cnt < 6) rd_log[rd_cnt] = bus.o_rd_addr;
      rd_cnt++;
    end
    if (bus.o_col_valid) begin
      col_cnt++;
      if (bus.o_newline) nl_cnt++;
      if (last_col_cyc >= 0) begin
        if (cyc - last_col_cyc < min_sp) min_sp = cyc - last_col_cyc;
        if (cyc - last_col_cyc > max_sp) max_sp = cyc - last_col_cyc;
      end
      last_col_cyc = cyc;
    end
    if (bus.o_wr_en) begin
      check("wr_lat", 32'(cv_d2), 32'd1);
      if (wr_cnt == 0) first_wr_data = bus.o_wr_data;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.o_wr_addr), 32'(e[ADDR_W+7:8]));
        check("wr_data", 32'(bus.o_wr_data), 32'(e[7:0]));
      end
      wr_cnt++;
    end
    cv_d2 = cv_d1;
    cv_d1 = bus.o_col_valid;
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
    if (o_busy) busy_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic load_image(input int h, input int w);
    for (int i = 0; i < h; i++)
      for (int j = 0; j < w; j++) mem[i*w + j] = 8'(5*i + j);
  endtask

  task automatic push_exp(input int addr, input int data);
    exp_q.push_back({ADDR_W'(addr), 8'(data)});
  endtask

  task automatic pulse_start(input int h, input int w, input int n);
    @(negedge clk);
    i_h = 8'(h); i_w = 8'(w); i_n = 8'(n); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin @(negedge clk); #1; i++; end
    check("done_timeout", 32'(done_cnt == 0), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic setup_5x5();
    clear_counts();
    cur_n = 3;
    load_image(5, 5);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) push_exp(OUT_BASE + i*3 + j, 5*i + j + 6);
  endtask

  task automatic check_5x5(input string tag);
    check({tag, "_reads"}, 32'(rd_cnt), 32'd45);
    check({tag, "_writes"}, 32'(wr_cnt), 32'd9);
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_newline"}, 32'(nl_cnt), 32'd3);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int i;
    clear_counts();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_rd_en", 32'(bus.o_rd_en), 32'd0);
    check("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    check("rst_col_valid", 32'(bus.o_col_valid), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b1;

    // 5x5, n=3 median
    setup_5x5();
    pulse_start(5, 5, 3);
    wait_done(400);
    check_5x5("a");
    check("a_rd0", 32'(rd_log[0]), 32'd0);
    check("a_rd1", 32'(rd_log[1]), 32'd5);
    check("a_rd2", 32'(rd_log[2]), 32'd10);
    check("a_rd3", 32'(rd_log[3]), 32'd1);
    check("a_rd4", 32'(rd_log[4]), 32'd6);
    check("a_rd5", 32'(rd_log[5]), 32'd11);
    check("a_first_data", 32'(first_wr_data), 32'd6);
    check("a_cols", 32'(col_cnt), 32'd15);

    // even n rejected
    clear_counts();
    @(negedge clk);
    i_h = 8'd5; i_w = 8'd5; i_n = 8'd4; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("b_state_check", 32'(state_dbg), 32'(ST_CHECK));
    check("b_err_early", 32'(o_err), 32'd0);
    @(negedge clk);
    check("b_err", 32'(o_err), 32'd1);
    @(negedge clk);
    check("b_err_pulse", 32'(o_err), 32'd0);
    repeat (5) @(negedge clk);
    check("b_reads", 32'(rd_cnt), 32'd0);
    check("b_busy", 32'(busy_seen), 32'd0);

    // n larger than MAX_N rejected
    clear_counts();
    pulse_start(8, 8, 7);
    repeat (6) @(negedge clk);
    check("c_err", 32'(err_cnt), 32'd1);
    check("c_reads", 32'(rd_cnt), 32'd0);
    check("c_busy", 32'(busy_seen), 32'd0);

    // h == n: single output row
    clear_counts();
    cur_n = 3;
    load_image(3, 4);
    push_exp(OUT_BASE, 6);
    push_exp(OUT_BASE + 1, 7);
    pulse_start(3, 4, 3);
    wait_done(200);
    check("d_reads", 32'(rd_cnt), 32'd12);
    check("d_writes", 32'(wr_cnt), 32'd2);
    check("d_min_sp", 32'(min_sp), 32'd3);
    check("d_max_sp", 32'(max_sp), 32'd3);
    check("d_newline", 32'(nl_cnt), 32'd1);
    check("d_exp_left", 32'(exp_q.size()), 32'd0);

    // n=1 identity
    clear_counts();
    cur_n = 1;
    load_image(2, 2);
    push_exp(OUT_BASE, 0);
    push_exp(OUT_BASE + 1, 1);
    push_exp(OUT_BASE + 2, 5);
    push_exp(OUT_BASE + 3, 6);
    pulse_start(2, 2, 1);
    wait_done(200);
    check("e_reads", 32'(rd_cnt), 32'd4);
    check("e_writes", 32'(wr_cnt), 32'd4);
    check("e_newline", 32'(nl_cnt), 32'd2);
    check("e_exp_left", 32'(exp_q.size()), 32'd0);

    // reset mid-READ on the 10th read
    setup_5x5();
    pulse_start(5, 5, 3);
    i = 0;
    while (rd_cnt < 10 && i < 100) begin @(negedge clk); #1; i++; end
    check("f_reach_10", 32'(rd_cnt), 32'd10);
    rst = 1'b0;
    #1;
    check("f_rd_en", 32'(bus.o_rd_en), 32'd0);
    check("f_rd_addr", 32'(bus.o_rd_addr), 32'd0);
    check("f_busy", 32'(o_busy), 32'd0);
    check("f_col_valid", 32'(bus.o_col_valid), 32'd0);
    check("f_col_data", 32'(bus.o_col_data), 32'd0);
    check("f_wr_en", 32'(bus.o_wr_en), 32'd0);
    check("f_state", 32'(state_dbg), 32'(ST_IDLE));
    clear_counts();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("f_no_writes", 32'(wr_cnt), 32'd0);
    check("f_no_reads", 32'(rd_cnt), 32'd0);
    check("f_no_done", 32'(done_cnt), 32'd0);
    setup_5x5();
    pulse_start(5, 5, 3);
    wait_done(400);
    check_5x5("f");

    // start pulsed during READ is ignored
    setup_5x5();
    pulse_start(5, 5, 3);
    i = 0;
    while (rd_cnt < 5 && i < 100) begin @(negedge clk); #1; i++; end
    @(negedge clk);
    i_h = 8'd2; i_w = 8'd2; i_n = 8'd1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(400);
    check_5x5("g");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule
